// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: SLC-3 bus memory responder with on-chip RAM, one I/O address,
// programmable ready latency and a side preload port.
`default_nettype none

module slc3_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_from_CPU,
  output logic [15:0]       Data_to_CPU,
  output logic              R,
  input  logic [9:0]        SW,
  output logic [15:0]       HEX_DATA,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [15:0]       Load_Data,
  output logic              Busy,
  output logic              Err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        wr_q;
  logic [15:0] dout_q;
  logic [15:0] hex_q;
  logic        err_q;

  logic [15:0] mem [DEPTH];

  logic        in_idle;
  logic        accept;
  logic        conflict;
  logic        enter_resp;
  logic [15:0] eff_addr;
  logic        eff_rd;
  logic        eff_io;
  logic        eff_in_range;
  logic        wr_io;
  logic        wr_in_range;
  logic        resp_wr;
  logic        load_we;
  logic        ram_we;

  assign in_idle  = (state_q == S_IDLE);
  assign accept   = in_idle && !Load_En && (Mem_OE ^ Mem_WE);
  assign conflict = in_idle && !Load_En && !Mem_OE && !Mem_WE;

  // With WAIT_CYCLES=0 the read happens on the acceptance edge, before the
  // captured registers hold the request, so the live bus is used there.
  assign eff_addr     = in_idle ? ADDR : addr_q;
  assign eff_rd       = in_idle ? !Mem_OE : !wr_q;
  assign eff_io       = (eff_addr == IO_ADDR);
  assign eff_in_range = ((32'(eff_addr) >> ADDR_W) == 32'd0);
  assign enter_resp   = (state_d == S_RESP) && (state_q != S_RESP);

  assign wr_io       = (addr_q == IO_ADDR);
  assign wr_in_range = ((32'(addr_q) >> ADDR_W) == 32'd0);
  assign resp_wr     = (state_q == S_RESP) && wr_q;

  assign load_we = in_idle && Load_En;
  assign ram_we  = resp_wr && !wr_io && wr_in_range;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!Load_En) begin
          if (Mem_OE ^ Mem_WE) begin
            state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end else if (!Mem_OE && !Mem_WE) begin
            state_d = S_HOLD;
          end
        end
      end
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  if (Mem_OE && Mem_WE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    R    = (state_q == S_RESP);
    Busy = (state_q != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= 4'd0;
      addr_q <= 16'd0;
      data_q <= 16'd0;
      wr_q   <= 1'b0;
      dout_q <= 16'd0;
      hex_q  <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= ADDR;
        data_q <= Data_from_CPU;
        wr_q   <= !Mem_WE;
        cnt_q  <= WAIT_LOAD;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (enter_resp && eff_rd) begin
        if (eff_io) begin
          dout_q <= {6'b0, SW};
        end else if (eff_in_range) begin
          dout_q <= mem[eff_addr[ADDR_W-1:0]];
        end else begin
          dout_q <= 16'h0000;
          err_q  <= 1'b1;
        end
      end

      if (resp_wr) begin
        if (wr_io) begin
          hex_q <= data_q;
        end else if (!wr_in_range) begin
          err_q <= 1'b1;
        end
      end

      if (conflict) begin
        err_q <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; the two write sources are exclusive by state.
  always_ff @(posedge Clk) begin
    if (load_we) begin
      mem[Load_Addr] <= Load_Data;
    end else if (ram_we) begin
      mem[addr_q[ADDR_W-1:0]] <= data_q;
    end
  end

  assign Data_to_CPU = dout_q;
  assign HEX_DATA    = hex_q;
  assign Err         = err_q;

endmodule

`default_nettype wire
